// File: rtl/l3_axi_line_mem_responder_if.sv
// Line-wide AXI channel bundle between the L3 cache (master) and the line memory responder (slave).
// Handshake rule for every channel: a beat transfers on a rising edge where valid && ready; once valid is raised,
// the sender holds valid and its payload stable until that edge, and valid never waits on ready.
interface l3_axi_line_mem_responder_if #(
    parameter int LINE_SIZE = 64
);
    logic                   awvalid;
    logic                   awready;
    logic [31:0]            awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [LINE_SIZE*8-1:0] wdata;
    logic [LINE_SIZE-1:0]   wstrb;
    logic                   wlast;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [31:0]            araddr;
    logic                   rvalid;
    logic                   rready;
    logic [LINE_SIZE*8-1:0] rdata;
    logic [1:0]             rresp;
    logic                   rlast;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/l3_axi_line_mem_responder.sv
// Single-beat line-wide AXI memory responder with fixed read/write latency, one transaction in flight.
// Optional macro MEM_RAND_STALL_EN adds an LFSR-driven 0-7 cycle stall to each access latency.
module l3_axi_line_mem_responder #(
    parameter int          LINE_SIZE     = 64,
    parameter int          DEPTH         = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          READ_LATENCY  = 8,
    parameter int          WRITE_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    l3_axi_line_mem_responder_if.slave    axi,
    output logic [2:0]                    dbg_state
);
    localparam int LINE_BITS = LINE_SIZE * 8;
    localparam int OFF_BITS  = $clog2(LINE_SIZE);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int CNT_W     = 16;
    localparam int RD_LAT    = (READ_LATENCY  < 1) ? 1 : READ_LATENCY;
    localparam int WR_LAT    = (WRITE_LATENCY < 1) ? 1 : WRITE_LATENCY;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
    localparam logic [32:0] SPAN = 33'(DEPTH * LINE_SIZE);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_WAIT = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]           state_q,   state_d;
    logic                 aw_held_q, aw_held_d;
    logic                 w_held_q,  w_held_d;
    logic [31:0]          aw_addr_q, aw_addr_d;
    logic [LINE_BITS-1:0] w_data_q,  w_data_d;
    logic [LINE_SIZE-1:0] w_strb_q,  w_strb_d;
    logic [31:0]          ar_addr_q, ar_addr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 bvalid_q,  bvalid_d;
    logic [1:0]           bresp_q,   bresp_d;
    logic                 rvalid_q,  rvalid_d;
    logic [LINE_BITS-1:0] rdata_q,   rdata_d;
    logic [1:0]           rresp_q,   rresp_d;
    logic                 mem_we;
    logic [2:0]           stall_extra;

    // Zero at power-up only; rst deliberately leaves the contents alone.
    logic [LINE_BITS-1:0] mem_q [DEPTH] = '{default: '0};

    // Offsets carry a borrow bit so addresses below BASE_ADDR fall out of range.
    logic [32:0]         wr_off, rd_off;
    logic                wr_oor, rd_oor;
    logic [IDX_BITS-1:0] wr_idx, rd_idx;

    assign wr_off = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
    assign rd_off = {1'b0, ar_addr_q} - {1'b0, BASE_ADDR};
    assign wr_oor = wr_off[32] || ({1'b0, wr_off[31:0]} >= SPAN);
    assign rd_oor = rd_off[32] || ({1'b0, rd_off[31:0]} >= SPAN);
    assign wr_idx = wr_off[OFF_BITS +: IDX_BITS];
    assign rd_idx = rd_off[OFF_BITS +: IDX_BITS];

    logic unused_bits;
    assign unused_bits = ^{axi.wlast, wr_off, rd_off};

`ifdef MEM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    assign stall_extra = lfsr_q[2:0];
`else
    assign stall_extra = 3'd0;
`endif

    // A partially captured write blocks reads, and any pending AW/W valid outranks AR.
    logic aw_hs, w_hs, ar_hs;
    assign axi.awready = (state_q == IDLE) && !aw_held_q;
    assign axi.wready  = (state_q == IDLE) && !w_held_q;
    assign axi.arready = (state_q == IDLE) && !aw_held_q && !w_held_q && !axi.awvalid && !axi.wvalid;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_addr_d = ar_addr_q;
        cnt_d     = cnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = axi.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = axi.wdata;
                    w_strb_d = axi.wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    state_d = WR_WAIT;
                    cnt_d   = WR_LOAD + CNT_W'(stall_extra);
                end else if (ar_hs) begin
                    ar_addr_d = axi.araddr;
                    state_d   = RD_WAIT;
                    cnt_d     = RD_LOAD + CNT_W'(stall_extra);
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we   = !wr_oor;
                    state_d  = WR_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = wr_oor ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_RESP: begin
                if (axi.bready) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RD_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = rd_oor ? '0 : mem_q[rd_idx];
                    rresp_d  = rd_oor ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_RESP: begin
                if (axi.rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    rdata_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_addr_q <= '0;
            cnt_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_addr_q <= ar_addr_d;
            cnt_q     <= cnt_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // A commit falling on a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                if (w_strb_q[i]) mem_q[wr_idx][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end

    assign axi.bvalid = bvalid_q;
    assign axi.bresp  = bresp_q;
    assign axi.rvalid = rvalid_q;
    assign axi.rlast  = rvalid_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_l3_axi_line_mem_responder.sv
// Directed bench for l3_axi_line_mem_responder: latency, strobes, split AW/W priority, backpressure, range, reset.
module tb_l3_axi_line_mem_responder;
    localparam int LS   = 64;
    localparam int RL   = 8;
    localparam int WL   = 4;
    localparam int LIM  = 50;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         checks;
    int         errors;
    logic [511:0] exp_q[$];

    l3_axi_line_mem_responder_if #(.LINE_SIZE(LS)) axi ();

    l3_axi_line_mem_responder #(
        .LINE_SIZE(LS), .DEPTH(1024), .BASE_ADDR(32'h0), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk), .rst(rst), .axi(axi.slave), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [511:0] data, input logic [63:0] strb,
                            input logic [1:0] exp_resp, input int bp);
        int k;
        @(negedge clk);
        axi.awvalid = 1'b1; axi.awaddr = addr;
        axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb; axi.wlast = 1'b1;
        #1;
        check("awready", axi.awready, 1);
        check("wready", axi.wready, 1);
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.wlast = 1'b0;
        k = 0;
        while (!axi.bvalid && k < LIM) begin
            @(negedge clk);
            k++;
        end
        check("b_latency", k, WL);
        check("bresp", axi.bresp, exp_resp);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bvalid_hold", axi.bvalid, 1);
            check("bresp_hold", axi.bresp, exp_resp);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("bvalid_clear", axi.bvalid, 0);
        check("state_idle_after_b", dbg_state, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [511:0] exp_data,
                           input logic [1:0] exp_resp, input int bp);
        int k;
        logic [511:0] exp;
        exp_q.push_back(exp_data);
        @(negedge clk);
        axi.arvalid = 1'b1; axi.araddr = addr;
        #1;
        check("arready", axi.arready, 1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        k = 0;
        while (!axi.rvalid && k < LIM) begin
            @(negedge clk);
            k++;
        end
        exp = exp_q.pop_front();
        check("r_latency", k, RL);
        check("rdata", axi.rdata, exp);
        check("rlast", axi.rlast, 1);
        check("rresp", axi.rresp, exp_resp);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("rvalid_hold", axi.rvalid, 1);
            check("rdata_hold", axi.rdata, exp);
            check("rresp_hold", axi.rresp, exp_resp);
        end
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check("rvalid_clear", axi.rvalid, 0);
        check("rlast_clear", axi.rlast, 0);
        check("rdata_clear", axi.rdata, 0);
    endtask

    initial begin
        int k;
        logic ar_leak;
        logic saw_rvalid;
        logic [511:0] d_a5, d_11, d_ff, d_part, d_77, d_3c, d_5a, d_c3;
        d_a5   = {64{8'hA5}};
        d_11   = {64{8'h11}};
        d_ff   = {64{8'hFF}};
        d_part = {{60{8'h11}}, {4{8'hFF}}};
        d_77   = {64{8'h77}};
        d_3c   = {64{8'h3C}};
        d_5a   = {64{8'h5A}};
        d_c3   = {64{8'hC3}};
        checks = 0;
        errors = 0;
        rst = 1'b1;
        axi.awvalid = 0; axi.awaddr = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
        axi.bready = 0; axi.arvalid = 0; axi.araddr = 0; axi.rready = 0;
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_rvalid", axi.rvalid, 0);
        check("rst_rlast", axi.rlast, 0);
        check("rst_bresp", axi.bresp, 0);
        check("rst_rresp", axi.rresp, 0);
        check("rst_rdata", axi.rdata, 0);
        rst = 1'b0;
        #1;
        check("idle_arready", axi.arready, 1);

        // Write then read, same-cycle AW+W
        do_write(32'h0000_0040, d_a5, {64{1'b1}}, OKAY, 0);
        do_read(32'h0000_0040, d_a5, OKAY, 0);
        do_read(32'h0000_0047, d_a5, OKAY, 0);

        // Partial strobe merge
        do_write(32'h0000_0000, d_11, {64{1'b1}}, OKAY, 0);
        do_write(32'h0000_0000, d_ff, 64'h0000_0000_0000_000F, OKAY, 0);
        do_read(32'h0000_0000, d_part, OKAY, 0);

        // Split AW/W with a competing read
        @(negedge clk);
        axi.awvalid = 1'b1; axi.awaddr = 32'h0000_0080;
        #1;
        check("split_awready", axi.awready, 1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.arvalid = 1'b1; axi.araddr = 32'h0000_0080;
        #1;
        check("split_ar_stall1", axi.arready, 0);
        @(negedge clk);
        check("split_ar_stall2", axi.arready, 0);
        check("split_wready", axi.wready, 1);
        @(negedge clk);
        axi.wvalid = 1'b1; axi.wdata = d_77; axi.wstrb = {64{1'b1}};
        #1;
        check("split_w_hs_wready", axi.wready, 1);
        check("split_awready_held", axi.awready, 0);
        @(negedge clk);
        axi.wvalid = 1'b0;
        k = 0;
        ar_leak = 1'b0;
        while (!axi.bvalid && k < LIM) begin
            if (axi.arready) ar_leak = 1'b1;
            @(negedge clk);
            k++;
        end
        check("split_b_latency", k, WL);
        check("split_ar_no_leak", ar_leak, 0);
        check("split_ar_stall_b", axi.arready, 0);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("split_bvalid_clear", axi.bvalid, 0);
        #1;
        check("split_arready_now", axi.arready, 1);
        exp_q.push_back(d_77);
        @(negedge clk);
        axi.arvalid = 1'b0;
        k = 0;
        while (!axi.rvalid && k < LIM) begin
            @(negedge clk);
            k++;
        end
        check("split_r_latency", k, RL);
        check("split_rdata", axi.rdata, exp_q.pop_front());
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check("split_rvalid_clear", axi.rvalid, 0);

        // Backpressure on B then R
        do_write(32'h0000_00C0, d_c3, {64{1'b1}}, OKAY, 5);
        do_read(32'h0000_00C0, d_c3, OKAY, 5);

        // Out of range just past the top, and last in-range line
        do_write(32'h0000_FFC0, d_3c, {64{1'b1}}, OKAY, 0);
        do_read(32'h0001_0000, '0, SLVERR, 0);
        do_write(32'h0001_0000, d_5a, {64{1'b1}}, SLVERR, 0);
        do_read(32'h0000_FFC0, d_3c, OKAY, 0);
        do_read(32'h0000_0000, d_part, OKAY, 0);

        // Reset during RD_WAIT
        @(negedge clk);
        axi.arvalid = 1'b1; axi.araddr = 32'h0000_0040;
        @(negedge clk);
        axi.arvalid = 1'b0;
        check("rstmid_in_rd_wait", dbg_state, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_state_idle", dbg_state, 0);
        saw_rvalid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (axi.rvalid) saw_rvalid = 1'b1;
            @(negedge clk);
        end
        check("rstmid_no_rvalid", saw_rvalid, 0);
        do_read(32'h0000_0040, d_a5, OKAY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l3_axi_line_mem_responder.md
Name: l3_axi_line_mem_responder

Overview:
- AXI responder (slave) that terminates the L3 data cache's line-wide AXI master port: one-beat 64-byte writebacks (AW/W/B) and refills (AR/R).
- Backs a line-granular storage array with configurable fixed access latency.
- Sits between the L3 controller and the system memory side; serves as the memory model for L3 miss/writeback flows and as the synthesizable on-chip backing store.

Parameters:
LINE_SIZE, 64, bytes per line; one beat carries LINE_SIZE*8 bits.
DEPTH, 1024, number of lines stored; power of two.
BASE_ADDR, 32'h0000_0000, byte address of line 0; must be aligned to DEPTH*LINE_SIZE.
READ_LATENCY, 8, cycles from AR handshake to first rvalid; values below 1 are treated as 1.
WRITE_LATENCY, 4, cycles from completed AW+W capture to bvalid; values below 1 are treated as 1.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
axi_awvalid  input  1  write address valid.
axi_awready  output  1  write address ready.
axi_awaddr  input  32  write byte address; low log2(LINE_SIZE) bits ignored.
axi_wvalid  input  1  write data valid.
axi_wready  output  1  write data ready.
axi_wdata  input  LINE_SIZE*8  full-line write data.
axi_wstrb  input  LINE_SIZE  byte enables; bit i covers wdata[8i+7:8i].
axi_wlast  input  1  ignored; single beat.
axi_bvalid  output  1  write response valid.
axi_bready  input  1  write response ready.
axi_bresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
axi_arvalid  input  1  read address valid.
axi_arready  output  1  read address ready.
axi_araddr  input  32  read byte address; low offset bits ignored.
axi_rvalid  output  1  read data valid.
axi_rready  input  1  read data ready.
axi_rdata  output  LINE_SIZE*8  full-line read data.
axi_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
axi_rlast  output  1  equals axi_rvalid (single beat).

Behaviour:
- Reset: state IDLE; aw_held and w_held clear.
- Reset values: axi_bvalid, axi_rvalid, axi_rlast = 0; axi_bresp, axi_rresp = 0; axi_rdata = 0.
- Storage is not cleared by rst. It is zero at time 0.
- Line index = addr[BLOCK_OFFSET_BITS +: log2(DEPTH)] after subtracting BASE_ADDR.
- Out of range = addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH*LINE_SIZE.
- States: IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP. One transaction in flight at a time.
- Ready generation (combinational):
  - axi_awready = IDLE && !aw_held.
  - axi_wready = IDLE && !w_held.
  - axi_arready = IDLE && !aw_held && !w_held && !axi_awvalid && !axi_wvalid. Writes have priority over reads.
  - AW and W may handshake in the same cycle or in different cycles; each is captured into a holding register (addr; data+strb).
- IDLE -> WR_WAIT: in the cycle where both AW and W are held or handshaking. The latency counter loads WRITE_LATENCY-1.
- WR_WAIT:
  - Counter decrements each cycle.
  - At 0: commit bytes with strb=1 to the line. No commit if out of range.
  - Go to WR_RESP with bvalid=1 and bresp = OKAY or SLVERR.
  - Net: bvalid rises WRITE_LATENCY cycles after the completing handshake.
- WR_RESP: hold bvalid and bresp stable until axi_bready. In the cycle after bready, return to IDLE with holds cleared. Back-to-back transactions are therefore separated by at least one IDLE cycle.
- IDLE -> RD_WAIT: on AR handshake. Capture the address; the counter loads READ_LATENCY-1.
- RD_WAIT: at 0, go to RD_RESP.
  - rvalid = rlast = 1.
  - rdata = line contents, or 0 with SLVERR if out of range.
  - Net: rvalid rises READ_LATENCY cycles after the AR handshake.
- RD_RESP: hold rvalid, rdata, rresp stable until axi_rready, then IDLE. Clear rvalid, rlast, rdata.
- Read-after-write to the same line: the write commits before its bvalid, so a subsequent read returns the new data.
- AR present while a write is partially captured (only AW or only W held): AR is stalled until the write completes.
- rst asserted mid-transaction: abort immediately, drop all valids, discard held data.
  - A commit scheduled for the reset cycle does not occur.
  - A write already committed stays in storage.

Optional Feature:
- Macro MEM_RAND_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1 on rst, advancing every cycle) adds an extra stall of lfsr[2:0] cycles (0-7).
  - The extra stall is sampled when entering WR_WAIT or RD_WAIT and is added to the latency counter.
  - Ordering and data are unaffected.
- Undefined: latencies are exactly WRITE_LATENCY / READ_LATENCY; no LFSR logic is present.

Test Plan:
- Write then read: AW+W in same cycle (addr 0x0000_0040, wdata all 0xA5, strb all 1).
  - Expect bvalid exactly 4 cycles later with bresp=00.
  - AR 0x0000_0040 then gives rvalid 8 cycles after the handshake with rdata all 0xA5 and rlast=1.
- Partial strobe: write 0x11 bytes to line 0 with full strb, then write 0xFF with strb=64'h0000_0000_0000_000F.
  - Readback: bytes 0-3 = 0xFF, bytes 4-63 = 0x11.
- Split AW/W and priority: AW at cycle 0, W at cycle 3, arvalid high from cycle 1.
  - arready stays 0 until the write's B handshake.
  - bvalid at cycle 7; the read is then serviced.
- Backpressure: hold bready=0 for 5 cycles, then rready=0 for 5 cycles.
  - bvalid/bresp and rvalid/rdata stay stable throughout; each completes one cycle after its ready.
- Out of range: AR at BASE_ADDR + DEPTH*64 gives rresp=10 and rdata=0.
  - Write at the same address gives bresp=10 and storage is unchanged (verified by reading line DEPTH-1).
- Reset mid-read: assert rst for one cycle during RD_WAIT.
  - rvalid never asserts and the FSM is in IDLE next cycle.
  - A previously written line reads back intact.
